shift_register_ctrl: RTL
========================

Name: shift_register_ctrl

Overview:
Frame sequencer for one shift_register instance.
- Accepts a parallel word and a direction over a valid/ready handshake.
- Drives the register's load/en/direction/parallel_in to load the word, then shifts exactly WIDTH bits, paced by a programmable divider.
- Signals completion with a one-cycle done pulse, and supports abort.
- Sits between a host/CSR block and the shift_register datapath.

Parameters:
WIDTH, 8, shift register width in bits; must match the shift_register instance.
DIV, 1, clock cycles per shift step (>=1); DIV=1 shifts every cycle.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  host requests a frame
start_ready  output  1  controller idle and can accept a frame
start_data  input  WIDTH  word to load
start_dir  input  1  shift direction for the frame (0 = new bit enters at bit 0, 1 = enters at bit WIDTH-1)
abort  input  1  terminate the current frame
sr_load  output  1  to shift_register.load
sr_en  output  1  to shift_register.en
sr_direction  output  1  to shift_register.direction
sr_parallel_in  output  WIDTH  to shift_register.parallel_in
sr_parallel_out  input  WIDTH  from shift_register.parallel_out
busy  output  1  frame in progress (state != IDLE)
bit_cnt  output  $clog2(WIDTH+1)  shifts completed in the current frame
done  output  1  one-cycle pulse: frame completed
aborted  output  1  one-cycle pulse: frame aborted

Behaviour:
- Reset: state=IDLE; start_ready=1; all other outputs 0, including sr_parallel_in, sr_direction, bit_cnt and the divider counter.
- Outputs are decoded from registered state.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch start_data into sr_parallel_in and start_dir into sr_direction; go to LOAD.
  - abort in IDLE is ignored, including when it coincides with start_valid.
- LOAD (exactly 1 cycle):
  - sr_load=1, sr_en=1.
  - Clear bit_cnt and div_cnt; go to SHIFT.
- SHIFT:
  - div_cnt counts 0..DIV-1.
  - sr_en=1 only in the cycle where div_cnt==DIV-1; bit_cnt increments on that same edge.
  - After the shift that brings bit_cnt to WIDTH, go to DONE.
- DONE (1 cycle):
  - done=1; go to IDLE.
  - sr_parallel_out is post-final-shift at this point.
- Latched values: sr_parallel_in and sr_direction hold their latched values until the next accepted start. Changes on start_data/start_dir mid-frame have no effect.
- Timing: handshake accepted in cycle 0 → LOAD in cycle 1 → first sr_en shift in cycle 1+DIV → last shift in cycle 1+WIDTH*DIV → done in cycle 2+WIDTH*DIV → start_ready=1 in cycle 3+WIDTH*DIV.
- Back-to-back frames are allowed with no extra gap.
- abort in LOAD/SHIFT/DONE:
  - Next state is IDLE; aborted=1 for one cycle; done is not asserted.
  - sr_en/sr_load=0 from the next cycle; bit_cnt holds its value until the next start.
  - abort in the same cycle as done: done wins and aborted stays 0.
- rst mid-frame: IDLE on the next edge, all outputs at reset values, no done/aborted pulse.
- Widths: bit_cnt saturates at WIDTH and never wraps. div_cnt width is $clog2(DIV) (minimum 1 bit) and wraps to 0 after each shift step.

Optional Feature:
Macro: SHIFT_REGISTER_CTRL_CAPTURE_EN
- Enabled: adds output port rx_data [WIDTH] (reset 0). In DONE it is loaded from sr_parallel_out and held until the next DONE, giving a received word for serial-in/full-duplex use. Not updated on abort.
- Disabled: the rx_data port and its register are absent; all other behaviour is identical.

Decomposition:
- Package shift_register_ctrl_pkg: state enum (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3) and the direction constants DIR_TOWARD_MSB=1'b1, DIR_TOWARD_LSB=1'b0.
- One sub-module, shift_pace_divider: wraps div_cnt and produces the step-tick, with a clear input driven by LOAD and by abort.

Test Plan:
- WIDTH=8, DIV=1; start 0xA5, dir=0 at cycle 0 → sr_load=1 in cycle 1; sr_en=1 in cycles 2-9 (8 pulses); done in cycle 10; bit_cnt=8; start_ready=1 in cycle 11.
- DIV=4, start 0x3C, dir=1 → sr_en pulses in cycles 5,9,...,33; done in cycle 34; sr_direction=1 throughout the frame; start_data changed to 0xFF mid-frame leaves sr_parallel_in=0x3C.
- DIV=1; abort in the cycle after the 3rd shift → IDLE next cycle; aborted pulse; no done; bit_cnt=3; sr_en=0 afterwards. abort applied while idle → no effect.
- rst held 20 cycles during SHIFT → busy=0, start_ready=1, sr_* outputs 0, bit_cnt=0; a new 0x81 frame then completes with done in cycle 10.
- start_valid held high across frames → second frame accepted the cycle start_ready reasserts; frame period = 11 cycles for DIV=1.
- CAPTURE_EN, DIV=1, shift_register serial in=1, dir=0, load 0x00 → rx_data=0xFF after done; with the macro off the bench compiles without rx_data.

Source files
------------

// File: rtl/shift_register_ctrl_pkg.sv
// Shared types and constants for the shift_register frame sequencer.
package shift_register_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Direction encoding seen by shift_register.direction
    localparam logic DIR_TOWARD_MSB = 1'b1;
    localparam logic DIR_TOWARD_LSB = 1'b0;

    // Divider counter width; a single bit is kept even when DIV=1
    function automatic int div_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shift_register_ctrl_pace.sv
// shift_pace_divider: paces shift steps, one step every DIV enabled cycles.
// The counter restarts from 0 on clr so every frame starts with a full period.
module shift_pace_divider
    import shift_register_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int DW = div_cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    assign step = en && (div_cnt == LAST);

    // Count 0..DIV-1 while enabled, wrapping on each step
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl: loads a word into a shift_register, shifts WIDTH bits
// at the divided pace, then pulses done (or aborted).
// Optional build macro SHIFT_REGISTER_CTRL_CAPTURE_EN adds rx_data, the
// register contents captured at the end of every completed frame.
//
// state | meaning
// IDLE  | waiting for a frame, start_ready high
// LOAD  | one cycle, parallel load into the shift register
// SHIFT | stepping, sr_en on every divider step
// DONE  | one cycle, done pulse, register holds the final word
module shift_register_ctrl
    import shift_register_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [WIDTH-1:0]             start_data,
    input  logic                         start_dir,
    input  logic                         abort,
    output logic                         sr_load,
    output logic                         sr_en,
    output logic                         sr_direction,
    output logic [WIDTH-1:0]             sr_parallel_in,
    input  logic [WIDTH-1:0]             sr_parallel_out,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         done,
    output logic                         aborted
`ifdef SHIFT_REGISTER_CTRL_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]             rx_data
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    ctrl_state_e state, state_next;
    logic        step;
    logic        div_clr;
    logic        last_step;
    logic        abort_act;
    logic        aborted_q;

    // abort is only meaningful inside a frame; in DONE the done pulse wins
    assign abort_act = abort && (state == LOAD || state == SHIFT);
    assign div_clr   = (state == LOAD) || (abort && state != IDLE);
    assign last_step = step && (bit_cnt == CW'(WIDTH - 1));

    shift_pace_divider #(.DIV(DIV)) u_pace (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (state == SHIFT),
        .step (step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_valid) state_next = LOAD;
            LOAD:  state_next = abort ? IDLE : SHIFT;
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the frame word and direction on handshake; held until next start
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_parallel_in <= '0;
            sr_direction   <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            sr_parallel_in <= start_data;
            sr_direction   <= start_dir;
        end
    end

    // Completed-shift counter, saturating at WIDTH, frozen by abort
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state == LOAD) begin
            bit_cnt <= '0;
        end else if (state == SHIFT && step && !abort && bit_cnt < CW'(WIDTH)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // One-cycle aborted pulse, visible once the FSM is back in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_act;
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign sr_load     = (state == LOAD);
    assign sr_en       = (state == LOAD) || (state == SHIFT && step);
    assign done        = (state == DONE);
    assign aborted     = aborted_q;

`ifdef SHIFT_REGISTER_CTRL_CAPTURE_EN
    // Capture the received word at the end of each completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
        end else if (state == DONE) begin
            rx_data <= sr_parallel_out;
        end
    end
`else
    logic sr_parallel_out_unused;
    assign sr_parallel_out_unused = ^sr_parallel_out;
`endif

endmodule
